serial_adder_seq: RTL and testbench
===================================

# serial_adder_seq

Bit-serial ripple adder that sits directly around the team's `full_adder` cell. It accepts two WIDTH-bit operands plus a carry-in through a valid/ready handshake. It streams the operands LSB-first through a single `full_adder` instance, with a registered carry fed back between bits. It returns the WIDTH-bit sum and the carry-out through a second valid/ready handshake, trading WIDTH cycles of latency for one adder cell.

## Interface
- `WIDTH`, default 8: operand and sum width; legal range WIDTH ≥ 2.
- `clk`  input  1  single clock; all state updates on the rising edge.
- `rst`  input  1  reset, asynchronous and active-high.
- `in_valid`  input  1  operand beat offered.
- `in_ready`  output  1  block can accept operands; high only in IDLE.
- `in_a`  input  WIDTH  operand A.
- `in_b`  input  WIDTH  operand B.
- `in_carry`  input  1  carry-in.
- `out_valid`  output  1  result available; high only in DONE.
- `out_ready`  input  1  consumer accepts result.
- `sum`  output  WIDTH  registered sum.
- `carry`  output  1  registered carry-out.
- `busy`  output  1  high in SHIFT or DONE.

## Operation
- **FSM states:** IDLE, SHIFT, DONE.
- **IDLE:**
  - in_ready=1.
  - On in_valid: load a_sr←in_a, b_sr←in_b, c_reg←in_carry, sum_sr←0, cnt←0, then go to SHIFT.
- **SHIFT (each cycle):**
  - The `full_adder` inputs are a_sr[0], b_sr[0] and c_reg.
  - a_sr and b_sr shift right with zero fill.
  - sum_sr shifts right, and the fa sum enters at bit WIDTH-1.
  - c_reg←fa carry and cnt←cnt+1.
  - When cnt==WIDTH-1, go to DONE.
- **DONE:**
  - out_valid=1, sum=sum_sr, carry=c_reg.
  - Both outputs are held stable while out_ready=0.
  - On out_ready, go to IDLE.
- **Arithmetic:** {carry,sum} = in_a + in_b + in_carry, computed modulo 2^(WIDTH+1) with no overflow flag.
- **Input while busy:** in_valid outside IDLE is ignored. in_ready=0, so no beat is lost under protocol.
- **Simultaneous events:** out_ready and in_valid in the same DONE cycle complete the output only. The new operand is accepted on the following IDLE cycle.
- **Reset values:** state=IDLE, every register 0, so sum=0, carry=0, out_valid=0, busy=0, in_ready=1.
- **Reset mid-operation:** asserting rst in SHIFT or DONE aborts immediately and asynchronously. There is no partial result and no out_valid pulse.
- **Operand hold:** in_a, in_b and in_carry are sampled only on the accept edge and may change afterwards.

## Timing
- **Accept:** the accept edge is T0 (in_valid && in_ready).
- **SHIFT:** occupies edges T1..TWIDTH, one bit per edge.
- **Result:** out_valid rises after edge TWIDTH, so latency is WIDTH cycles from accept to out_valid.
- **Throughput:** minimum initiation interval is WIDTH+2 cycles (accept, WIDTH shifts, DONE handshake, IDLE).
- **Outputs:** all outputs are registered or decoded from the state register only. There is no combinational path from in_* or out_ready to any output.
- **Carry path:** the `full_adder` path is purely combinational between registers. The critical path is one full-adder delay plus the c_reg setup time.

## Structure
- **Package `serial_adder_pkg`:**
  - State typedef: IDLE=2'd0, SHIFT=2'd1, DONE=2'd2.
  - Counter width localparam CNT_W = $clog2(WIDTH).
- **Sub-module:** one instance of the existing `full_adder` cell (in_a, in_b, in_carry → sum, carry), used unmodified.
- **Top-level contents:** FSM, counter, three shift registers and c_reg.

## Test plan
- **Basic add:** WIDTH=8; 0x5A + 0x33 + 0 → sum=0x8D, carry=0. out_valid must rise exactly 8 cycles after accept.
- **Carry ripple:** 0xFF + 0x01 + 0 → sum=0x00, carry=1. Then 0xFF + 0xFF + 1 → sum=0xFF, carry=1.
- **Backpressure:**
  - Hold out_ready=0 for 5 cycles in DONE. sum, carry and out_valid must stay stable, and in_ready must stay 0.
  - A new in_valid with 0x11 during this time is not accepted.
  - After release, in_ready=1 on the next cycle, and the new beat produces 0x11 + its operand correctly.
- **Reset mid-SHIFT:** assert rst at cycle 3 of SHIFT. Outputs must go to 0, out_valid=0 and in_ready=1 immediately. The next transaction, 0x10 + 0x20 + 1, gives 0x31, carry=0.
- **Random regression:** 2,000 random {in_a, in_b, in_carry} with random out_ready stalls, run at WIDTH=8 and WIDTH=2. Each result is checked against in_a + in_b + in_carry, and exactly one output is produced per accepted input.

Source files
------------

// File: rtl/serial_adder_pkg.sv
// Shared types and sizing helpers for the bit-serial adder.
package serial_adder_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SHIFT = 2'd1,
    DONE  = 2'd2
  } state_e;

  localparam int WIDTH_DEF = 8;
  localparam int CNT_W     = $clog2(WIDTH_DEF);

  // Counter width for an arbitrary operand width (WIDTH >= 2 keeps this >= 1).
  function automatic int cnt_width(input int width);
    return $clog2(width);
  endfunction

endpackage

// File: rtl/full_adder.sv
// Single-bit full adder cell.
module full_adder (
  input  logic in_a,
  input  logic in_b,
  input  logic in_carry,
  output logic sum,
  output logic carry
);

  assign sum   = in_a ^ in_b ^ in_carry;
  assign carry = (in_a & in_b) | (in_carry & (in_a ^ in_b));

endmodule

// File: rtl/serial_adder_seq.sv
// Bit-serial ripple adder: one full_adder cell, operands streamed LSB-first,
// carry held in a register between bits. Latency is WIDTH cycles.
module serial_adder_seq
  import serial_adder_pkg::*;
#(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] in_a,
  input  logic [WIDTH-1:0] in_b,
  input  logic             in_carry,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] sum,
  output logic             carry,
  output logic             busy
);

  localparam int               CW       = cnt_width(WIDTH);
  localparam logic [CW-1:0]    CNT_LAST = CW'(WIDTH - 1);

  state_e           state_q, state_d;
  logic [WIDTH-1:0] a_q, a_d;
  logic [WIDTH-1:0] b_q, b_d;
  logic [WIDTH-1:0] s_q, s_d;
  logic             c_q, c_d;
  logic [CW-1:0]    cnt_q, cnt_d;
  logic             fa_sum, fa_carry;

  full_adder u_fa (
    .in_a     (a_q[0]),
    .in_b     (b_q[0]),
    .in_carry (c_q),
    .sum      (fa_sum),
    .carry    (fa_carry)
  );

  // State and datapath registers; reset aborts any in-flight add.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
      a_q     <= '0;
      b_q     <= '0;
      s_q     <= '0;
      c_q     <= 1'b0;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      a_q     <= a_d;
      b_q     <= b_d;
      s_q     <= s_d;
      c_q     <= c_d;
      cnt_q   <= cnt_d;
    end
  end

  // Next-state: load on accept, shift one bit per cycle, hold result until taken.
  always_comb begin
    state_d = state_q;
    a_d     = a_q;
    b_d     = b_q;
    s_d     = s_q;
    c_d     = c_q;
    cnt_d   = cnt_q;
    unique case (state_q)
      IDLE: begin
        if (in_valid) begin
          a_d     = in_a;
          b_d     = in_b;
          c_d     = in_carry;
          s_d     = '0;
          cnt_d   = '0;
          state_d = SHIFT;
        end
      end
      SHIFT: begin
        a_d   = {1'b0, a_q[WIDTH-1:1]};
        b_d   = {1'b0, b_q[WIDTH-1:1]};
        s_d   = {fa_sum, s_q[WIDTH-1:1]};
        c_d   = fa_carry;
        cnt_d = cnt_q + CW'(1);
        if (cnt_q == CNT_LAST) state_d = DONE;
      end
      DONE: begin
        // A new in_valid here is not taken: in_ready is low until IDLE.
        if (out_ready) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  // All outputs come straight from registers or the state decode.
  assign in_ready  = (state_q == IDLE);
  assign out_valid = (state_q == DONE);
  assign busy      = (state_q == SHIFT) || (state_q == DONE);
  assign sum       = s_q;
  assign carry     = c_q;

endmodule

// File: tb/tb_serial_adder_seq.sv
module tb_serial_adder_seq;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  // WIDTH=8 instance: directed tests plus random regression
  logic       v8 = 0, rdy8, ov8, or8 = 0, c8 = 0, co8, busy8;
  logic [7:0] a8 = 0, b8 = 0, s8;
  // WIDTH=2 instance: random regression in parallel
  logic       v2 = 0, rdy2, ov2, or2 = 0, c2 = 0, co2, busy2;
  logic [1:0] a2 = 0, b2 = 0, s2;

  serial_adder_seq #(.WIDTH(8)) dut8 (
    .clk(clk), .rst(rst), .in_valid(v8), .in_ready(rdy8), .in_a(a8), .in_b(b8),
    .in_carry(c8), .out_valid(ov8), .out_ready(or8), .sum(s8), .carry(co8), .busy(busy8));

  serial_adder_seq #(.WIDTH(2)) dut2 (
    .clk(clk), .rst(rst), .in_valid(v2), .in_ready(rdy2), .in_a(a2), .in_b(b2),
    .in_carry(c2), .out_valid(ov2), .out_ready(or2), .sum(s2), .carry(co2), .busy(busy2));

  int checks = 0;
  int fails  = 0;
  logic [8:0] sb8[$];
  logic [2:0] sb2[$];
  int n_acc8 = 0, n_out8 = 0, n_acc2 = 0, n_out2 = 0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Scoreboard: push on accept, pop and compare on output handshake.
  always @(negedge clk) begin
    if (!rst) begin
      if (v8 && rdy8) begin
        sb8.push_back({1'b0, a8} + {1'b0, b8} + {8'd0, c8});
        n_acc8++;
      end
      if (ov8 && or8) begin
        n_out8++;
        if (sb8.size() == 0) chk("w8_unexpected_out", 32'd1, 32'd0);
        else chk("w8_result", {23'd0, co8, s8}, {23'd0, sb8.pop_front()});
      end
      if (v2 && rdy2) begin
        sb2.push_back({1'b0, a2} + {1'b0, b2} + {2'd0, c2});
        n_acc2++;
      end
      if (ov2 && or2) begin
        n_out2++;
        if (sb2.size() == 0) chk("w2_unexpected_out", 32'd1, 32'd0);
        else chk("w2_result", {29'd0, co2, s2}, {29'd0, sb2.pop_front()});
      end
    end
  end

  // Offer a beat, wait (bounded) for acceptance, then scramble the operands.
  task automatic send8(input logic [7:0] a, input logic [7:0] b, input logic c);
    int k = 0;
    v8 = 1; a8 = a; b8 = b; c8 = c;
    while (!rdy8 && k < 50) begin step(); k++; end
    if (k >= 50) chk("w8_accept_timeout", 32'd1, 32'd0);
    step();
    v8 = 0; a8 = 8'($urandom); b8 = 8'($urandom); c8 = 1'($urandom);
  endtask

  task automatic wait_out8(output int lat);
    lat = 0;
    while (!ov8 && lat < 50) begin step(); lat++; end
    if (lat >= 50) chk("w8_out_timeout", 32'd1, 32'd0);
  endtask

  task automatic release8();
    or8 = 1; step(); or8 = 0;
  endtask

  initial begin
    int lat;
    #12;
    // reset state
    chk("rst_sum", {24'd0, s8}, 32'h0);
    chk("rst_carry", {31'd0, co8}, 32'd0);
    chk("rst_out_valid", {31'd0, ov8}, 32'd0);
    chk("rst_busy", {31'd0, busy8}, 32'd0);
    chk("rst_in_ready", {31'd0, rdy8}, 32'd1);
    chk("rst_in_ready_w2", {31'd0, rdy2}, 32'd1);
    rst = 0;
    step();

    // basic add and exact latency
    send8(8'h5A, 8'h33, 1'b0);
    wait_out8(lat);
    chk("latency", lat, 32'd8);
    chk("basic_sum", {24'd0, s8}, 32'h8D);
    chk("basic_carry", {31'd0, co8}, 32'd0);
    release8();
    chk("idle_after_basic", {31'd0, rdy8}, 32'd1);

    // carry ripple
    send8(8'hFF, 8'h01, 1'b0);
    wait_out8(lat);
    chk("ripple1_sum", {24'd0, s8}, 32'h00);
    chk("ripple1_carry", {31'd0, co8}, 32'd1);
    release8();
    send8(8'hFF, 8'hFF, 1'b1);
    wait_out8(lat);
    chk("ripple2_sum", {24'd0, s8}, 32'hFF);
    chk("ripple2_carry", {31'd0, co8}, 32'd1);
    release8();

    // backpressure: hold DONE for 5 cycles while a new beat is offered
    send8(8'hAA, 8'h77, 1'b0);
    wait_out8(lat);
    v8 = 1; a8 = 8'h11; b8 = 8'h22; c8 = 0;
    for (int i = 0; i < 5; i++) begin
      step();
      chk("bp_out_valid", {31'd0, ov8}, 32'd1);
      chk("bp_sum", {24'd0, s8}, 32'h21);
      chk("bp_carry", {31'd0, co8}, 32'd1);
      chk("bp_in_ready", {31'd0, rdy8}, 32'd0);
    end
    or8 = 1; step(); or8 = 0;            // DONE handshake with in_valid still high
    chk("bp_in_ready_after", {31'd0, rdy8}, 32'd1);
    chk("bp_out_valid_after", {31'd0, ov8}, 32'd0);
    step();                              // the held beat is accepted now
    v8 = 0;
    wait_out8(lat);
    chk("bp_new_sum", {24'd0, s8}, 32'h33);
    release8();

    // reset in the middle of SHIFT
    send8(8'h77, 8'h66, 1'b1);
    step(); step();
    #2 rst = 1;
    #1;
    chk("mid_rst_sum", {24'd0, s8}, 32'h0);
    chk("mid_rst_carry", {31'd0, co8}, 32'd0);
    chk("mid_rst_out_valid", {31'd0, ov8}, 32'd0);
    chk("mid_rst_in_ready", {31'd0, rdy8}, 32'd1);
    chk("mid_rst_busy", {31'd0, busy8}, 32'd0);
    sb8.delete();
    sb2.delete();
    n_acc8--;
    step();
    rst = 0;
    step();
    send8(8'h10, 8'h20, 1'b1);
    wait_out8(lat);
    chk("post_rst_sum", {24'd0, s8}, 32'h31);
    chk("post_rst_carry", {31'd0, co8}, 32'd0);
    release8();

    // random regressions on both widths in parallel
    fork
      begin
        for (int i = 0; i < 2000; i++) begin
          while ($urandom_range(3) == 0) step();
          send8(8'($urandom), 8'($urandom), 1'($urandom));
          wait_out8(lat);
          while ($urandom_range(2) == 0) step();
          release8();
        end
      end
      begin
        for (int i = 0; i < 2000; i++) begin
          int k = 0;
          v2 = 1; a2 = 2'($urandom); b2 = 2'($urandom); c2 = 1'($urandom);
          while (!rdy2 && k < 50) begin step(); k++; end
          if (k >= 50) chk("w2_accept_timeout", 32'd1, 32'd0);
          step();
          v2 = 0;
          k = 0;
          while (!ov2 && k < 50) begin step(); k++; end
          if (k >= 50) chk("w2_out_timeout", 32'd1, 32'd0);
          while ($urandom_range(2) == 0) step();
          or2 = 1; step(); or2 = 0;
        end
      end
    join
    step();

    chk("w8_sb_empty", sb8.size(), 32'd0);
    chk("w8_one_out_per_in", n_out8, n_acc8);
    chk("w2_sb_empty", sb2.size(), 32'd0);
    chk("w2_one_out_per_in", n_out2, n_acc2);
    $display("TB_RESULT checks=%0d failures=%0d", checks, fails);
    $finish;
  end

endmodule
